// File: rtl/pc_check_queue.sv
// pc_check_queue: compares DUT-attempted PCs against a FIFO of expected records from a reference model.
// Optional trace output is compiled in when PC_CHECK_TRACE_EN is defined.
module pc_check_queue #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int DEPTH = 8,
  parameter logic [XLEN-1:0] START_PC = 'h1000,
  parameter int MAX_MISS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ref_valid,
  input  logic [XLEN-1:0] ref_pc,
  input  logic [ILEN-1:0] ref_inst,
  output logic            ref_ready,
  input  logic            try_valid,
  input  logic [XLEN-1:0] pc_try,
  output logic            try_ready,
  output logic [XLEN-1:0] pc_factual,
  output logic [ILEN-1:0] inst,
  output logic            ok,
  output logic            miss,
  output logic            fatal,
  output logic [15:0]     miss_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_MISS + 1);
  typedef enum logic [1:0] {IDLE, RUN, FATAL} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [CW-1:0] consec, consec_inc;
  logic push, store, try_acc, hit, pop;
  assign ref_ready = state != FATAL && count < (AW+1)'(DEPTH);
  assign try_ready = state == RUN && count != '0;
  assign fatal = state == FATAL;
  assign push = ref_valid && ref_ready;
  assign store = push && (state != IDLE || ref_pc == START_PC);
  assign try_acc = try_valid && try_ready;
  assign hit = pc_try == pc_mem[rptr];
  assign pop = try_acc && hit;
  assign consec_inc = consec + 1'b1;
  // Next state: first push decides RUN vs FATAL; MAX_MISS consecutive misses are fatal.
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && push) ? (ref_pc == START_PC ? RUN : FATAL)
            : (try_acc && !hit && consec_inc == CW'(MAX_MISS)) ? FATAL : state;
  end
  // Control state: FSM, FIFO pointers/count and consecutive-miss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      consec <= '0;
    end else begin
      state <= state_n;
      wptr <= wptr + AW'(store);
      rptr <= rptr + AW'(pop);
      count <= count + {AW'(0), store} - {AW'(0), pop};
      consec <= pop ? '0 : (try_acc ? consec_inc : consec);
    end
  end
  // Record storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (store) begin
      pc_mem[wptr] <= ref_pc;
      inst_mem[wptr] <= ref_inst;
    end
  end
  // Registered result of each accepted try; holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_factual <= '0;
      inst <= '0;
      ok <= 1'b0;
      miss <= 1'b0;
      miss_cnt <= '0;
    end else if (try_acc) begin
      pc_factual <= pc_mem[rptr];
      inst <= inst_mem[rptr];
      ok <= hit;
      miss <= !hit;
      miss_cnt <= (!hit && miss_cnt != 16'hFFFF) ? miss_cnt + 16'd1 : miss_cnt;
    end
  end
`ifdef PC_CHECK_TRACE_EN
  // Trace each result as it is registered.
  always_ff @(posedge clk) begin
    if (!rst && try_acc)
      if (hit) $display("%x ok %x %x", pc_try, pc_mem[rptr], inst_mem[rptr]);
      else $display("%x miss %x", pc_try, pc_mem[rptr]);
  end
`endif
endmodule

// File: tb/tb_pc_check_queue.sv
// tb_pc_check_queue: directed plus random scoreboard bench for pc_check_queue.
module tb_pc_check_queue;
  localparam int DEPTH = 8;
  localparam int MAX_MISS = 4;
  localparam logic [63:0] START = 64'h1000;
  logic clk, rst, ref_valid, ref_ready, try_valid, try_ready, ok, miss, fatal;
  logic [63:0] ref_pc, pc_try, pc_factual;
  logic [31:0] ref_inst, inst;
  logic [15:0] miss_cnt;
  pc_check_queue #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .START_PC(START), .MAX_MISS(MAX_MISS)) dut (
    .clk(clk), .rst(rst), .ref_valid(ref_valid), .ref_pc(ref_pc), .ref_inst(ref_inst),
    .ref_ready(ref_ready), .try_valid(try_valid), .pc_try(pc_try), .try_ready(try_ready),
    .pc_factual(pc_factual), .inst(inst), .ok(ok), .miss(miss), .fatal(fatal), .miss_cnt(miss_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct packed {logic [63:0] pc; logic [31:0] inst;} rec_t;
  typedef struct packed {logic ok; logic miss; logic [63:0] pc; logic [31:0] inst; logic [15:0] mc;} res_t;
  rec_t mq[$];
  res_t sb[$];
  res_t last;
  int mst, consec, mmc, total, bad;
  bit hs;
  logic [63:0] npc;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic model(input logic r, input logic rv, input logic [63:0] rpc, input logic [31:0] ri,
                       input logic tv, input logic [63:0] tpc);
    int st0;
    bit rr, tr, h;
    res_t x;
    rec_t rec;
    if (r) begin
      mq.delete();
      mst = 0;
      consec = 0;
      mmc = 0;
      last = '0;
      return;
    end
    st0 = mst;
    rr = mst != 2 && mq.size() < DEPTH;
    tr = mst == 1 && mq.size() != 0;
    if (tv && tr) begin
      h = tpc == mq[0].pc;
      if (!h && mmc < 65535) mmc++;
      x.ok = h;
      x.miss = !h;
      x.pc = mq[0].pc;
      x.inst = mq[0].inst;
      x.mc = 16'(mmc);
      if (h) begin
        void'(mq.pop_front());
        consec = 0;
      end else begin
        consec++;
        if (consec == MAX_MISS) mst = 2;
      end
      sb.push_back(x);
      last = x;
    end
    if (rv && rr) begin
      rec.pc = rpc;
      rec.inst = ri;
      if (st0 != 0) mq.push_back(rec);
      else if (rpc == START) begin
        mq.push_back(rec);
        mst = 1;
      end else mst = 2;
    end
  endtask
  task automatic cyc(input logic r, input logic rv, input logic [63:0] rpc, input logic [31:0] ri,
                     input logic tv, input logic [63:0] tpc);
    rst = r;
    ref_valid = rv;
    ref_pc = rpc;
    ref_inst = ri;
    try_valid = tv;
    pc_try = tpc;
    #1;
    chk("ref_ready", 64'(ref_ready), 64'(mst != 2 && mq.size() < DEPTH));
    chk("try_ready", 64'(try_ready), 64'(mst == 1 && mq.size() != 0));
    @(posedge clk);
    model(r, rv, rpc, ri, tv, tpc);
    @(negedge clk);
    chk("fatal", 64'(fatal), 64'(mst == 2));
    chk("ok", 64'(ok), 64'(last.ok));
    chk("miss", 64'(miss), 64'(last.miss));
    chk("pc_factual", pc_factual, last.pc);
    chk("inst", 64'(inst), 64'(last.inst));
    chk("miss_cnt", 64'(miss_cnt), 64'(last.mc));
  endtask
  task automatic rstc();
    cyc(1'b1, 1'b1, START, 32'h0, 1'b1, START);
  endtask
  task automatic push(input logic [63:0] pc);
    cyc(1'b0, 1'b1, pc, $urandom, 1'b0, 64'h0);
  endtask
  task automatic try_pc(input logic [63:0] pc);
    cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b1, pc);
  endtask
  function automatic logic [63:0] head();
    return mq.size() != 0 ? mq[0].pc : 64'h0;
  endfunction
  // Scoreboard monitor: on every DUT handshake, compare the next cycle's result with the queued expectation.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #3;
      hs = try_valid && try_ready && !rst;
      @(posedge clk);
      #1;
      if (hs) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty actual=accepted_try expected=no_try");
        end else begin
          e = sb.pop_front();
          chk("sb_ok", 64'(ok), 64'(e.ok));
          chk("sb_miss", 64'(miss), 64'(e.miss));
          chk("sb_pc", pc_factual, e.pc);
          chk("sb_inst", 64'(inst), 64'(e.inst));
          chk("sb_miss_cnt", 64'(miss_cnt), 64'(e.mc));
        end
      end
    end
  end
  initial begin
    logic r, rv, tv;
    logic [63:0] rpc, tpc;
    total = 0;
    bad = 0;
    rst = 1'b1;
    ref_valid = 1'b0;
    try_valid = 1'b0;
    ref_pc = '0;
    pc_try = '0;
    ref_inst = '0;
    model(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rstc();
    push(64'h1000); push(64'h1004); push(64'h1008);
    try_pc(64'h1000); try_pc(64'h1004);
    try_pc(64'hAAAA1008); try_pc(64'hBBBB1008); try_pc(64'h1008);
    npc = 64'h100c;
    for (int i = 0; i < 9; i++) begin
      push(npc);
      npc += 4;
    end
    cyc(1'b0, 1'b1, npc, $urandom, 1'b1, head());
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, npc, $urandom, 1'b1, head());
      npc += 4;
    end
    while (mq.size() != 0) try_pc(head());
    rstc();
    push(64'h1000); try_pc(64'h1000); push(64'h1010);
    try_pc(64'hCCCC1010); try_pc(64'hDDDD1010); try_pc(64'hEEEE1010); try_pc(64'hFFFF1010);
    cyc(1'b0, 1'b1, 64'h1014, 32'h5, 1'b1, 64'h1010);
    rstc();
    push(64'h2000);
    cyc(1'b0, 1'b1, START, 32'h7, 1'b1, START);
    rstc();
    push(64'h1000); push(64'h1004); push(64'h1008); try_pc(64'h1000); push(64'h100c);
    rstc();
    try_pc(64'h1000);
    push(64'h1000);
    try_pc(64'h1000);
    npc = 64'h1004;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom % 200 == 0) || (mst == 2 && $urandom % 4 == 0);
      rv = 1'($urandom % 2);
      rpc = mst == 0 ? ($urandom % 10 == 0 ? 64'h2000 : START) : npc;
      tv = $urandom % 3 != 0;
      tpc = mq.size() != 0 ? ($urandom % 5 == 0 ? head() ^ {32'($urandom) | 32'h1, 32'h0} : head())
                           : {32'h0, 32'($urandom)};
      cyc(r, rv, rpc, $urandom, tv, tpc);
      if (rv) npc += 4;
      if (r || mst == 0) npc = START + 4;
    end
    chk("sb_drain", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
